// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, opcode values and state/halt-cause encodings for the A7 fetch sequencer.
package fetch_sequencer_pkg;

    localparam int unsigned NUM_INSTR = 8;
    localparam int unsigned PC_W      = 4;
    localparam int unsigned MAX_FETCH = 64;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned OPC_W     = 6;

    localparam logic [OPC_W-1:0] OP_R    = 6'b000000;
    localparam logic [OPC_W-1:0] OP_J    = 6'b000010;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'b001000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        HC_NONE  = 2'd0,
        HC_END   = 2'd1,
        HC_JUMP  = 2'd2,
        HC_LIMIT = 2'd3
    } halt_cause_e;

    function automatic logic is_jump(input logic [OPC_W-1:0] opcode);
        return opcode == OP_J;
    endfunction

endpackage

// File: rtl/fetch_sequencer_npc.sv
// Next-pc and halt decision for the instruction currently held in the output buffer.
module fetch_sequencer_npc
    import fetch_sequencer_pkg::*;
(
    input  logic [PC_W-1:0]  pc,
    input  logic [OPC_W-1:0] opcode,
    input  logic [PC_W-1:0]  target,
    input  logic [CNT_W-1:0] count,
    output logic [PC_W-1:0]  next_pc_c,
    output logic [CNT_W-1:0] count_inc_c,
    output logic             halt_c,
    output logic [1:0]       cause_c
);

    logic [PC_W:0] next_wide;
    logic          jump;

    // Carry bit of the sequential increment is kept so running off the end is detectable.
    always_comb begin
        jump        = is_jump(opcode);
        next_wide   = jump ? {1'b0, target} : ({1'b0, pc} + (PC_W+1)'(1));
        count_inc_c = (&count) ? count : (count + CNT_W'(1));
        cause_c     = HC_NONE;
        if ((MAX_FETCH != 0) && (count_inc_c == CNT_W'(MAX_FETCH))) begin
            cause_c = HC_LIMIT;
        end else if (next_wide >= (PC_W+1)'(NUM_INSTR)) begin
            cause_c = jump ? HC_JUMP : HC_END;
        end
        halt_c    = (cause_c != HC_NONE);
        next_pc_c = next_wide[PC_W-1:0];
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives pc into the instruction memory, buffers the returned word
// and hands it to decode over a valid/ready handshake, halting on end/jump-out/limit.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] mem_instr,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               halted,
    output logic [1:0]         halt_cause,
    output logic [CNT_W-1:0]   fetch_count
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [PC_W-1:0]    next_pc_c;
    logic [CNT_W-1:0]   count_inc_c;
    logic               halt_c;
    logic [1:0]         cause_c;

    fetch_sequencer_npc u_npc (
        .pc          (pc_q),
        .opcode      (instr_q[INSTR_W-1 -: OPC_W]),
        .target      (instr_q[PC_W-1:0]),
        .count       (count_q),
        .next_pc_c   (next_pc_c),
        .count_inc_c (count_inc_c),
        .halt_c      (halt_c),
        .cause_c     (cause_c)
    );

    // Next-state logic; pc only moves on the transition into ISSUE.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        cause_d  = cause_q;
        count_d  = count_q;
        unique case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (start) begin
                    count_d = '0;
                    cause_d = HC_NONE;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                instr_d = mem_instr;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (valid_q && instr_ready) begin
                    valid_d = 1'b0;
                    count_d = count_inc_c;
                    if (halt_c) begin
                        halted_d = 1'b1;
                        cause_d  = cause_c;
                        state_d  = ST_DONE;
                    end else begin
                        pc_d    = next_pc_c;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                valid_d = 1'b0;
                if (start) begin
                    pc_d     = '0;
                    count_d  = '0;
                    cause_d  = HC_NONE;
                    halted_d = 1'b0;
                    state_d  = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cause_q  <= HC_NONE;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
        end
    end

    assign pc          = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign halt_cause  = cause_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: program-level reference model checked every cycle, plus directed literal checks.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              instr_ready;
    logic [PC_W-1:0]   pc;
    logic [31:0]       mem_instr;
    logic [31:0]       instr_out;
    logic              instr_valid;
    logic              halted;
    logic [1:0]        halt_cause;
    logic [CNT_W-1:0]  fetch_count;

    int tests_run = 0;
    int fails     = 0;

    logic [31:0] mem [NUM_INSTR];

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } exp_t;

    // Reference model state: the list of deliveries a run must produce, plus handshake timing.
    exp_t q[$];
    int   fin_cause;
    bit   running;
    bit   exp_valid;
    int   wait_n;
    int   m_count;
    int   m_halted;
    int   m_cause;
    int   m_pc;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pc          (pc),
        .mem_instr   (mem_instr),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .fetch_count (fetch_count)
    );

    // Synchronous memory: word for pc appears one cycle after pc is presented.
    always @(posedge clk)
        mem_instr <= (pc < PC_W'(NUM_INSTR)) ? mem[pc[2:0]] : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Interpret the program from pc 0 and list every delivery and the final halt cause.
    function automatic void gen();
        int p = 0;
        int n = 0;
        int t;
        logic [31:0] w;
        bit isj;
        q.delete();
        while (1) begin
            w = mem[p];
            q.push_back('{pc: PC_W'(p), instr: w});
            n++;
            isj = (w[31:26] == OP_J);
            t   = isj ? int'(w[PC_W-1:0]) : p + 1;
            if (MAX_FETCH != 0 && n == int'(MAX_FETCH)) begin fin_cause = 3; break; end
            if (t >= int'(NUM_INSTR)) begin fin_cause = isj ? 2 : 1; break; end
            p = t;
        end
    endfunction

    // Compare process: every falling edge, DUT outputs against the model.
    initial begin
        running = 0; wait_n = 0; m_count = 0; m_halted = 0; m_cause = 0; m_pc = 0; fin_cause = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                running = 0; q.delete(); wait_n = 0;
                m_count = 0; m_halted = 0; m_cause = 0; m_pc = 0;
                check("rst_valid", 32'(instr_valid), 0);
                check("rst_instr", instr_out, 0);
                check("rst_pc", 32'(pc), 0);
                check("rst_count", 32'(fetch_count), 0);
                check("rst_halted", 32'(halted), 0);
                check("rst_cause", 32'(halt_cause), 0);
            end else begin
                exp_valid = running && (wait_n == 0);
                check("valid", 32'(instr_valid), 32'(exp_valid));
                if (exp_valid) check("instr", instr_out, q[0].instr);
                check("pc", 32'(pc), 32'(m_pc));
                check("count", 32'(fetch_count), 32'(m_count));
                check("halted", 32'(halted), 32'(m_halted));
                check("cause", 32'(halt_cause), 32'(m_cause));
                if (running) begin
                    if (wait_n > 0) begin
                        wait_n--;
                    end else if (instr_ready) begin
                        void'(q.pop_front());
                        if (m_count < 255) m_count++;
                        if (q.size() == 0) begin
                            running = 0; m_halted = 1; m_cause = fin_cause;
                        end else begin
                            wait_n = 2; m_pc = int'(q[0].pc);
                        end
                    end
                end else if (start) begin
                    gen();
                    running = 1; wait_n = 2;
                    m_count = 0; m_halted = 0; m_cause = 0; m_pc = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 1000 && !halted; i++) step();
        check(name, 32'(halted), 1);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !instr_valid; i++) step();
        check(name, 32'(instr_valid), 1);
    endtask

    task automatic load_linear();
        for (int i = 0; i < int'(NUM_INSTR); i++)
            mem[i] = (i % 2 == 1) ? {OP_R, 26'(i * 3 + 1)} : {OP_ADDI, 26'(i + 100)};
    endtask

    task automatic load_random();
        for (int i = 0; i < int'(NUM_INSTR); i++)
            mem[i] = ($urandom_range(0, 9) < 2) ? {OP_J, 26'($urandom_range(0, 15))}
                                                : {OP_ADDI, 26'($urandom)};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b1;
        load_linear();
        step(); step();
        rst_n = 1'b1;
        step();

        // Standard program: word 7 jumps to 6, loops until the fetch limit.
        load_linear();
        mem[7] = {OP_J, 26'd6};
        pulse_start();
        wait_halt("t1_halt");
        check("t1_count", 32'(fetch_count), 64);
        check("t1_cause", 32'(halt_cause), 3);
        check("t1_pc", 32'(pc), 7);

        // Out-of-range jump at pc 2.
        load_linear();
        mem[2] = {OP_J, 26'hA};
        pulse_start();
        wait_halt("t3_halt");
        check("t3_count", 32'(fetch_count), 3);
        check("t3_cause", 32'(halt_cause), 2);
        check("t3_pc", 32'(pc), 2);

        // Straight-line program with ready held low in HOLD and spurious starts.
        load_linear();
        instr_ready = 1'b0;
        pulse_start();
        pulse_start();
        wait_valid("t4_valid");
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            step();
            check("t4_hold_valid", 32'(instr_valid), 1);
            check("t4_hold_instr", instr_out, {OP_ADDI, 26'd100});
            check("t4_hold_pc", 32'(pc), 0);
            check("t4_hold_count", 32'(fetch_count), 0);
        end
        start = 1'b0;
        instr_ready = 1'b1;
        step();
        check("t4_release_count", 32'(fetch_count), 1);
        check("t4_release_valid", 32'(instr_valid), 0);
        wait_halt("t2_halt");
        check("t2_count", 32'(fetch_count), 8);
        check("t2_cause", 32'(halt_cause), 1);
        check("t2_pc", 32'(pc), 7);

        // Restart from DONE.
        instr_ready = 1'b0;
        pulse_start();
        check("t6_count", 32'(fetch_count), 0);
        check("t6_cause", 32'(halt_cause), 0);
        check("t6_halted", 32'(halted), 0);
        step(); step();
        check("t6_valid", 32'(instr_valid), 1);
        check("t6_instr", instr_out, {OP_ADDI, 26'd100});

        // Asynchronous reset while an instruction is buffered.
        rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(instr_valid), 0);
        check("t5_pc", 32'(pc), 0);
        check("t5_count", 32'(fetch_count), 0);
        step();
        rst_n = 1'b1;
        instr_ready = 1'b1;
        step();
        pulse_start();
        wait_halt("t5_halt");
        check("t5_final_cause", 32'(halt_cause), 1);

        // Randomized programs, ready, start pulses and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if (!running && $urandom_range(0, 3) == 0) load_random();
            instr_ready = ($urandom_range(0, 9) < 7);
            start       = ($urandom_range(0, 24) == 0);
            rst_n       = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1; start = 1'b0; instr_ready = 1'b1;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
